pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the LC2K CPU.
- Holds the PC register and selects the next PC from four sources: sequential (PC+1), BEQ-taken (PC+1+sign-extended offset), JALR target, and hold.
- Presents the PC to instruction memory with a valid/ready handshake.
- Adds stall and halt states, and defers a redirect that arrives while a fetch is still outstanding.

Parameters:
- PC_W, 16, PC/address width in bits; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 16, width of the BEQ offset field; sign-extended (or truncated) to PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_valid  out  1  pc is a valid fetch address.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- pc  out  PC_W  current PC.
- pc_plus_one  out  PC_W  pc+1 mod 2^PC_W, combinational from pc.
- beq_taken  in  1  branch redirect request.
- beq_offset  in  OFF_W  signed branch offset.
- jalr_en  in  1  jump redirect request.
- jalr_target  in  PC_W  jump target (regA value).
- stall  in  1  hold PC, suppress fetch.
- halt  in  1  enter HALT permanently, until reset.
- halted  out  1  high in HALT.
- redirect_pending  out  1  a deferred redirect is held.

Behaviour:
- Reset (rst_n low, async):
  - pc=RESET_PC, state=RUN, pending cleared.
  - fetch_valid=0 while rst_n low; 1 from the first edge after release.
  - halted=0, redirect_pending=0.
- States: RUN, STALL, HALT. fetch_valid=1 only in RUN.
- Handshake: fetch accepted when fetch_valid && fetch_ready. pc must stay stable while fetch_valid=1 and not yet accepted.
- Redirect target:
  - jalr_en -> jalr_target.
  - else beq_taken -> pc_plus_one + sext(beq_offset), mod 2^PC_W.
  - jalr_en and beq_taken together: JALR wins.
- Per rising edge, priority order:
  1. halt -> state HALT; pc holds; pending discarded. halt has priority over everything.
  2. Redirect with RUN, fetch_valid=1, fetch_ready=0 -> target captured in pend_target, redirect_pending=1, pc holds. A newer redirect overwrites pend_target.
  3. Redirect otherwise (accepted or not fetching) -> pc=target next cycle, pending cleared.
  4. redirect_pending=1 and fetch accepted or state≠RUN -> pc=pend_target, pending cleared.
  5. stall -> state STALL, pc holds.
  6. Fetch accepted -> pc=pc_plus_one.
  7. Otherwise pc holds.
- STALL -> RUN on the first edge with stall=0 and halt=0. Redirects are applied during STALL, per rules 3/4.
- HALT is absorbing until rst_n low:
  - all inputs ignored; fetch_valid=0, halted=1, pc frozen.
- Wrap-around: pc=2^PC_W-1 sequential -> 0. Negative offsets wrap the same way.
- Latency: redirect visible on pc one cycle after the request (two or more if deferred).

Decomposition:
- Shared package lc2k_pkg holds:
  - state enum (RUN/STALL/HALT);
  - default PC_W/OFF_W constants;
  - sext function.
- One sub-module, pc_next_sel (combinational): priority select of the next PC; instantiated under the state register.

Test Plan:
- Reset release, fetch_ready=1 for 4 cycles -> pc 0,1,2,3; fetch_valid=1 from cycle 1.
- pc=5, beq_taken=1, beq_offset=-3 (OFF_W=16) -> pc=3 next cycle. Same with offset 0x7FFF at PC_W=16, pc=0xFFF0 -> pc=0x7FF0 (wrap).
- pc=8, fetch_ready=0, jalr_en=1, jalr_target=40 -> pc stays 8, redirect_pending=1. fetch_ready=1 next cycle -> handshake at 8, then pc=40, pending=0.
- jalr_en and beq_taken together at pc=10, jalr_target=2, offset=5 -> pc=2.
- stall=1 for 3 cycles at pc=7 -> fetch_valid=0, pc=7. Release -> fetch_valid=1, pc=7 then 8.
- halt=1 at pc=12 with jalr_en=1 -> halted=1, pc=12 frozen for 10 cycles. Async rst_n pulse mid-cycle -> pc=RESET_PC immediately, halted=0.

Source files
------------

// File: rtl/lc2k_pkg.sv
// Shared LC2K PC-unit types, default widths and the offset sign-extension helper.
package lc2k_pkg;

  localparam int unsigned PC_W_DEF  = 16;
  localparam int unsigned OFF_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

  // Sign-extends the low w bits of v to 64 bits; callers truncate to their width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    logic [63:0] r;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = v & m;
    if (((r >> (w - 1)) & 64'd1) != 64'd0) begin
      r = r | ~m;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch handshake plus redirect/stall/halt controls between the PC unit and its neighbours.
interface pc_unit_if #(
  parameter int unsigned PC_W  = lc2k_pkg::PC_W_DEF,
  parameter int unsigned OFF_W = lc2k_pkg::OFF_W_DEF
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus_one;
  logic             beq_taken;
  logic [OFF_W-1:0] beq_offset;
  logic             jalr_en;
  logic [PC_W-1:0]  jalr_target;
  logic             stall;
  logic             halt;
  logic             halted;
  logic             redirect_pending;

  modport master (
    output fetch_valid, pc, pc_plus_one, halted, redirect_pending,
    input  fetch_ready, beq_taken, beq_offset, jalr_en, jalr_target, stall, halt
  );

  modport slave (
    input  fetch_valid, pc, pc_plus_one, halted, redirect_pending,
    output fetch_ready, beq_taken, beq_offset, jalr_en, jalr_target, stall, halt
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-state select for the PC unit: halt, redirect, deferred redirect,
// stall and sequential advance, in that priority.
module pc_next_sel
  import lc2k_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned OFF_W = OFF_W_DEF
) (
  input  pc_state_e        i_state,
  input  logic             i_fetch_valid,
  input  logic             i_fetch_ready,
  input  logic             i_halt,
  input  logic             i_stall,
  input  logic             i_beq_taken,
  input  logic [OFF_W-1:0] i_beq_offset,
  input  logic             i_jalr_en,
  input  logic [PC_W-1:0]  i_jalr_target,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [PC_W-1:0]  i_pc_plus_one,
  input  logic             i_pend,
  input  logic [PC_W-1:0]  i_pend_target,
  output pc_state_e        o_state,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_pend,
  output logic [PC_W-1:0]  o_pend_target
);

  logic            w_redir;
  logic            w_accept;
  logic [PC_W-1:0] w_beq_target;
  logic [PC_W-1:0] w_target;

  assign w_redir      = i_jalr_en || i_beq_taken;
  assign w_accept     = i_fetch_valid && i_fetch_ready;
  assign w_beq_target = i_pc_plus_one + PC_W'(sext(64'(i_beq_offset), OFF_W));
  assign w_target     = i_jalr_en ? i_jalr_target : w_beq_target;

  always_comb begin
    o_state       = i_state;
    o_pc          = i_pc;
    o_pend        = i_pend;
    o_pend_target = i_pend_target;
    if (i_state == ST_HALT) begin
      o_state = ST_HALT;
    end else if (i_halt) begin
      o_state = ST_HALT;
      o_pend  = 1'b0;
    end else begin
      o_state = i_stall ? ST_STALL : ST_RUN;
      // An unaccepted fetch must keep pc stable, so the redirect is parked instead.
      if (w_redir && (i_state == ST_RUN) && i_fetch_valid && !i_fetch_ready) begin
        o_pend        = 1'b1;
        o_pend_target = w_target;
      end else if (w_redir) begin
        o_pc   = w_target;
        o_pend = 1'b0;
      end else if (i_pend && (w_accept || (i_state != ST_RUN))) begin
        o_pc   = i_pend_target;
        o_pend = 1'b0;
      end else if (!i_stall && w_accept) begin
        o_pc = i_pc_plus_one;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// LC2K program-counter unit: PC register, run/stall/halt state and fetch handshake.
module pc_unit
  import lc2k_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     OFF_W    = OFF_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_unit_if.master  bus
);

  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_plus_one;
  logic            r_pend;
  logic            w_pend_nxt;
  logic [PC_W-1:0] r_pend_target;
  logic [PC_W-1:0] w_pend_target_nxt;
  logic            r_started;
  logic            w_fetch_valid;

  // r_started keeps fetch_valid low until the first edge after reset release.
  assign w_fetch_valid = r_started && (r_state == ST_RUN);
  assign w_pc_plus_one = r_pc + PC_W'(1);

  assign bus.fetch_valid      = w_fetch_valid;
  assign bus.pc               = r_pc;
  assign bus.pc_plus_one      = w_pc_plus_one;
  assign bus.halted           = (r_state == ST_HALT);
  assign bus.redirect_pending = r_pend;

  pc_next_sel #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next_sel (
    .i_state       (r_state),
    .i_fetch_valid (w_fetch_valid),
    .i_fetch_ready (bus.fetch_ready),
    .i_halt        (bus.halt),
    .i_stall       (bus.stall),
    .i_beq_taken   (bus.beq_taken),
    .i_beq_offset  (bus.beq_offset),
    .i_jalr_en     (bus.jalr_en),
    .i_jalr_target (bus.jalr_target),
    .i_pc          (r_pc),
    .i_pc_plus_one (w_pc_plus_one),
    .i_pend        (r_pend),
    .i_pend_target (r_pend_target),
    .o_state       (w_state_nxt),
    .o_pc          (w_pc_nxt),
    .o_pend        (w_pend_nxt),
    .o_pend_target (w_pend_target_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_pend        <= 1'b0;
      r_pend_target <= '0;
      r_started     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_started     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_pc_unit;

  localparam int              PC_W     = 16;
  localparam int              OFF_W    = 16;
  localparam logic [15:0]     RESET_PC = 16'h0000;
  localparam int              MASK     = 32'h0000_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

  pc_unit #(
    .PC_W     (PC_W),
    .OFF_W    (OFF_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: mode 0 = running, 1 = stalled, 2 = halted.
  int m_pc, m_mode, m_pend, m_ptgt, m_started;
  int lit_pc = -1, lit_pend = -1, lit_halt = -1, lit_fv = -1;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc      <= int'(RESET_PC);
      m_mode    <= 0;
      m_pend    <= 0;
      m_ptgt    <= 0;
      m_started <= 0;
    end else begin
      automatic int  fv    = (m_started != 0 && m_mode == 0) ? 1 : 0;
      automatic bit  acc   = (fv != 0) && bus.fetch_ready;
      automatic bit  redir = bus.jalr_en || bus.beq_taken;
      automatic int  off   = int'($signed(bus.beq_offset));
      automatic int  tgt   = bus.jalr_en ? int'(bus.jalr_target) : ((m_pc + 1 + off) & MASK);
      m_started <= 1;
      if (m_mode == 2) begin
        m_mode <= 2;
      end else if (bus.halt) begin
        m_mode <= 2;
        m_pend <= 0;
      end else begin
        m_mode <= bus.stall ? 1 : 0;
        if (redir && fv != 0 && !bus.fetch_ready) begin
          m_pend <= 1;
          m_ptgt <= tgt;
        end else if (redir) begin
          m_pc   <= tgt;
          m_pend <= 0;
        end else if (m_pend != 0 && (acc || m_mode != 0)) begin
          m_pc   <= m_ptgt;
          m_pend <= 0;
        end else if (acc && !bus.stall) begin
          m_pc <= (m_pc + 1) & MASK;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pc", int'(bus.pc), m_pc);
    chk("pc_plus_one", int'(bus.pc_plus_one), (m_pc + 1) & MASK);
    chk("fetch_valid", int'(bus.fetch_valid), (m_started != 0 && m_mode == 0) ? 1 : 0);
    chk("halted", int'(bus.halted), (m_mode == 2) ? 1 : 0);
    chk("redirect_pending", int'(bus.redirect_pending), m_pend);
    if (lit_pc >= 0)   chk("lit_pc", int'(bus.pc), lit_pc);
    if (lit_pend >= 0) chk("lit_pending", int'(bus.redirect_pending), lit_pend);
    if (lit_halt >= 0) chk("lit_halted", int'(bus.halted), lit_halt);
    if (lit_fv >= 0)   chk("lit_fetch_valid", int'(bus.fetch_valid), lit_fv);
  end

  task automatic drv(input bit j, input int tgt, input bit b, input int off,
                     input bit rdy, input bit st, input bit h);
    bus.jalr_en     = j;
    bus.jalr_target = 16'(tgt);
    bus.beq_taken   = b;
    bus.beq_offset  = 16'(off);
    bus.fetch_ready = rdy;
    bus.stall       = st;
    bus.halt        = h;
  endtask

  task automatic set_lits(input int epc, input int epend, input int ehalt, input int efv);
    lit_pc   = epc;
    lit_pend = epend;
    lit_halt = ehalt;
    lit_fv   = efv;
  endtask

  task automatic cyc(input int epc, input int epend, input int ehalt, input int efv);
    set_lits(epc, epend, ehalt, efv);
    @(posedge clk);
    #1;
  endtask

  // Reset pulse straddling the negedge, between two rising edges.
  task automatic rst_cyc(input int epc, input int epend, input int ehalt, input int efv);
    set_lits(epc, epend, ehalt, efv);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    drv(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(2, 0, 0, 1);
    cyc(3, 0, 0, 1);
    cyc(4, 0, 0, 1);

    drv(0, 0, 1, -3, 1, 0, 0);        cyc(5, 0, 0, 1);
    drv(1, 'hFFF0, 0, 0, 1, 0, 0);    cyc(3, 0, 0, 1);
    drv(0, 0, 1, 'h7FFF, 1, 0, 0);    cyc('hFFF0, 0, 0, 1);
    drv(1, 'hFFFF, 0, 0, 1, 0, 0);    cyc('h7FF0, 0, 0, 1);
    drv(0, 0, 0, 0, 1, 0, 0);         cyc('hFFFF, 0, 0, 1);
    cyc(0, 0, 0, 1);

    drv(1, 8, 0, 0, 1, 0, 0);         cyc(1, 0, 0, 1);
    drv(1, 40, 0, 0, 0, 0, 0);        cyc(8, 0, 0, 1);
    drv(0, 0, 0, 0, 1, 0, 0);         cyc(8, 1, 0, 1);
    cyc(40, 0, 0, 1);

    drv(1, 10, 0, 0, 1, 0, 0);        cyc(41, 0, 0, 1);
    drv(1, 2, 1, 5, 1, 0, 0);         cyc(10, 0, 0, 1);
    drv(1, 7, 0, 0, 1, 0, 0);         cyc(2, 0, 0, 1);

    drv(0, 0, 0, 0, 1, 1, 0);
    cyc(7, 0, 0, 1);
    cyc(7, 0, 0, 0);
    cyc(7, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    cyc(7, 0, 0, 0);
    cyc(7, 0, 0, 1);

    drv(1, 12, 0, 0, 1, 0, 0);        cyc(8, 0, 0, 1);
    drv(1, 99, 0, 0, 1, 0, 1);        cyc(12, 0, 0, 1);
    drv(1, 50, 1, 3, 1, 1, 0);
    repeat (10) cyc(12, 0, 1, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    rst_cyc(int'(RESET_PC), 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      automatic bit j   = ($urandom % 6) == 0;
      automatic bit b   = ($urandom % 5) == 0;
      automatic int tgt = (($urandom % 4) == 0) ? int'(16'hFFFC) + int'($urandom % 4) : int'($urandom % 65536);
      automatic int off = (($urandom % 2) == 0) ? int'($urandom % 17) - 8 : int'($urandom % 65536);
      automatic bit rdy = ($urandom % 3) != 0;
      automatic bit st  = ($urandom % 8) == 0;
      automatic bit h   = ($urandom % 150) == 0;
      drv(j, tgt, b, off, rdy, st, h);
      if ((m_mode == 2 && ($urandom % 10) == 0) || ($urandom % 400) == 0)
        rst_cyc(-1, -1, -1, -1);
      else
        cyc(-1, -1, -1, -1);
    end

    set_lits(-1, -1, -1, -1);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
